// File: rtl/cf_fft_1024_8_pkg.sv
// rtl/cf_fft_1024_8_pkg.sv - shared types and constants for the FFT operand-select sequencer
package cf_fft_1024_8_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_e;

  // Mux select codes as wired on the 4:1 operand mux
  localparam logic [2:0] SEL_SRC1 = 3'b000;
  localparam logic [2:0] SEL_SRC2 = 3'b101;
  localparam logic [2:0] SEL_SRC3 = 3'b011;
  localparam logic [2:0] SEL_SRC4 = 3'b001;

  localparam int N_LOG2_DEF    = 10;
  localparam int STAGES_DEF    = 10;
  localparam int FLUSH_CYC_DEF = 2;

endpackage

// File: rtl/cf_fft_1024_8_sel_seq_if.sv
// rtl/cf_fft_1024_8_sel_seq_if.sv - control/select bundle between the sequencer and its user
interface cf_fft_1024_8_sel_seq_if
  import cf_fft_1024_8_pkg::*;
#(
  parameter int N_LOG2 = N_LOG2_DEF
);

  logic              enable_i;
  logic              sync_i;
  logic [2:0]        sel_o;
  logic              sync_o;
  logic [N_LOG2-1:0] index_o;
  logic [3:0]        stage_o;
  logic              busy_o;
  logic              done_o;

  modport master (
    output enable_i, sync_i,
    input  sel_o, sync_o, index_o, stage_o, busy_o, done_o
  );

  modport slave (
    input  enable_i, sync_i,
    output sel_o, sync_o, index_o, stage_o, busy_o, done_o
  );

endinterface

// File: rtl/cf_fft_1024_8_sel_enc.sv
// rtl/cf_fft_1024_8_sel_enc.sv - maps the 2-bit rotated operand slot to the mux select code
module cf_fft_1024_8_sel_enc
  import cf_fft_1024_8_pkg::*;
(
  input  logic [1:0] s_i,
  output logic [2:0] sel_o
);

  always_comb begin
    sel_o = SEL_SRC1;
    case (s_i)
      2'd0:    sel_o = SEL_SRC1;
      2'd1:    sel_o = SEL_SRC2;
      2'd2:    sel_o = SEL_SRC3;
      default: sel_o = SEL_SRC4;
    endcase
  end

endmodule

// File: rtl/cf_fft_1024_8_sel_seq.sv
// rtl/cf_fft_1024_8_sel_seq.sv - frame/stage sequencer driving the FFT 4:1 operand-select code
module cf_fft_1024_8_sel_seq
  import cf_fft_1024_8_pkg::*;
#(
  parameter int N_LOG2    = N_LOG2_DEF,
  parameter int STAGES    = STAGES_DEF,
  parameter int FLUSH_CYC = FLUSH_CYC_DEF
)(
  input  logic                    clock_c,
  input  logic                    reset_i,
  cf_fft_1024_8_sel_seq_if.slave  bus
);

  localparam int FW = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;
  localparam logic [N_LOG2-1:0] CNT_MAX   = '1;
  localparam logic [N_LOG2-1:0] CNT_ONE   = N_LOG2'(1);
  localparam logic [3:0]        STG_LAST  = 4'(STAGES - 1);
  localparam logic [FW-1:0]     FCNT_LAST = FW'(FLUSH_CYC - 1);
  localparam logic [FW-1:0]     FCNT_ONE  = FW'(1);

  state_e            state_q, state_d;
  logic [N_LOG2-1:0] cnt_q, cnt_d;
  logic [3:0]        stg_q, stg_d;
  logic [FW-1:0]     fcnt_q, fcnt_d;
  logic              restart, finish;

  logic [2:0]        sel_q;
  logic              sync_q;
  logic [N_LOG2-1:0] index_q;
  logic [3:0]        stage_q;
  logic              busy_q;
  logic              done_q;

  logic [1:0]        slot;
  logic [2:0]        enc_sel;

  // Operand slot rotates with the stage; 2-bit add drops the carry
  assign slot = cnt_d[1:0] + stg_d[1:0];

  cf_fft_1024_8_sel_enc u_enc (
    .s_i   (slot),
    .sel_o (enc_sel)
  );

  // A frame-start strobe always wins, including over RUN exit and the last FLUSH cycle
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stg_d   = stg_q;
    fcnt_d  = fcnt_q;
    restart = 1'b0;
    finish  = 1'b0;
    if (bus.sync_i) begin
      state_d = RUN;
      cnt_d   = '0;
      stg_d   = '0;
      fcnt_d  = '0;
      restart = 1'b1;
    end else begin
      case (state_q)
        RUN: begin
          if (cnt_q == CNT_MAX) begin
            cnt_d = '0;
            if (stg_q == STG_LAST) begin
              state_d = FLUSH;
              stg_d   = '0;
              fcnt_d  = '0;
            end else begin
              stg_d = stg_q + 4'd1;
            end
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        FLUSH: begin
          if (fcnt_q == FCNT_LAST) begin
            state_d = IDLE;
            fcnt_d  = '0;
            finish  = 1'b1;
          end else begin
            fcnt_d = fcnt_q + FCNT_ONE;
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs are registered from the next state so they line up with the counters they describe
  always_ff @(posedge clock_c) begin
    if (reset_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      stg_q   <= '0;
      fcnt_q  <= '0;
      sel_q   <= SEL_SRC1;
      sync_q  <= 1'b0;
      index_q <= '0;
      stage_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else if (bus.enable_i) begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      stg_q   <= stg_d;
      fcnt_q  <= fcnt_d;
      sel_q   <= (state_d == RUN) ? enc_sel : SEL_SRC1;
      sync_q  <= restart;
      index_q <= (state_d == RUN) ? cnt_d : '0;
      stage_q <= (state_d == RUN) ? stg_d : '0;
      busy_q  <= (state_d != IDLE);
      done_q  <= finish;
    end
  end

  assign bus.sel_o   = sel_q;
  assign bus.sync_o  = sync_q;
  assign bus.index_o = index_q;
  assign bus.stage_o = stage_q;
  assign bus.busy_o  = busy_q;
  assign bus.done_o  = done_q;

endmodule

// File: tb/tb_cf_fft_1024_8_sel_seq.sv
// tb/tb_cf_fft_1024_8_sel_seq.sv - self-checking bench for the FFT operand-select sequencer
module tb_cf_fft_1024_8_sel_seq;

  typedef struct packed {
    logic [2:0] sel;
    logic       sync;
    logic [9:0] idx;
    logic [3:0] stg;
    logic       busy;
    logic       done;
  } obs_t;

  logic clock_c = 1'b0;
  logic reset_i = 1'b1;
  always #5 clock_c = ~clock_c;

  cf_fft_1024_8_sel_seq_if #(.N_LOG2(10)) bus ();

  cf_fft_1024_8_sel_seq dut (
    .clock_c (clock_c),
    .reset_i (reset_i),
    .bus     (bus)
  );

  int   n_assert = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   done_seen = 0;
  obs_t exp_q[$];

  int   ms = 0, mc = 0, mg = 0, mf = 0;
  obs_t mexp = '0;
  logic [2:0] sel_tab [4] = '{3'b000, 3'b101, 3'b011, 3'b001};

  task automatic model(input logic rst, input logic en, input logic sy);
    int s;
    logic fin;
    if (rst) begin
      ms = 0; mc = 0; mg = 0; mf = 0; mexp = '0;
      return;
    end
    if (!en) return;
    fin = 1'b0;
    if (sy) begin
      ms = 1; mc = 0; mg = 0;
    end else if (ms == 1) begin
      if (mc == 1023 && mg == 9) begin ms = 2; mf = 0; end
      else if (mc == 1023) begin mc = 0; mg = mg + 1; end
      else mc = mc + 1;
    end else if (ms == 2) begin
      if (mf == 1) begin ms = 0; fin = 1'b1; end
      else mf = mf + 1;
    end
    s = (mc + mg) % 4;
    mexp.sel  = (ms == 1) ? sel_tab[s] : 3'b000;
    mexp.sync = sy;
    mexp.idx  = (ms == 1) ? 10'(mc) : 10'd0;
    mexp.stg  = (ms == 1) ? 4'(mg) : 4'd0;
    mexp.busy = (ms != 0);
    mexp.done = fin;
  endtask

  task automatic step(input logic rst, input logic en, input logic sy);
    obs_t got, e;
    reset_i      = rst;
    bus.enable_i = en;
    bus.sync_i   = sy;
    model(rst, en, sy);
    exp_q.push_back(mexp);
    @(posedge clock_c);
    #1;
    cyc++;
    got = {bus.sel_o, bus.sync_o, bus.index_o, bus.stage_o, bus.busy_o, bus.done_o};
    e = exp_q.pop_front();
    if (bus.done_o) done_seen++;
    n_assert++;
    assert (got === e) else begin
      n_fail++;
      $error("FAIL scoreboard cyc=%0d observed=%h expected=%h", cyc, got, e);
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  initial begin
    int busy_n, max_stg, mark;
    bus.enable_i = 1'b1;
    bus.sync_i   = 1'b0;

    repeat (3) step(1'b1, 1'b1, 1'b1);
    chk("reset_outputs", {bus.sel_o, bus.sync_o, bus.index_o, bus.stage_o, bus.busy_o, bus.done_o}, 0);

    step(1'b0, 1'b1, 1'b1);
    chk("start_sync", bus.sync_o, 1);
    chk("start_sel", bus.sel_o, 3'b000);
    chk("start_idx_stg_busy", {bus.index_o, bus.stage_o, bus.busy_o}, {10'd0, 4'd0, 1'b1});
    step(1'b0, 1'b1, 1'b0);
    chk("sel_idx1", bus.sel_o, 3'b101);
    step(1'b0, 1'b1, 1'b0);
    chk("sel_idx2", bus.sel_o, 3'b011);
    step(1'b0, 1'b1, 1'b0);
    chk("sel_idx3", bus.sel_o, 3'b001);
    repeat (1021) step(1'b0, 1'b1, 1'b0);
    chk("stg1_pos", {bus.stage_o, bus.index_o}, {4'd1, 10'd0});
    chk("stg1_sel_rot", bus.sel_o, 3'b101);

    // Full frame from a fresh start (also a restart while in RUN)
    mark = done_seen;
    step(1'b0, 1'b1, 1'b1);
    busy_n = 1;
    max_stg = 0;
    for (int i = 0; i < 11000 && !bus.done_o; i++) begin
      step(1'b0, 1'b1, 1'b0);
      if (bus.busy_o) busy_n++;
      if (int'(bus.stage_o) > max_stg) max_stg = int'(bus.stage_o);
    end
    chk("frame_done", bus.done_o, 1);
    chk("frame_busy_cycles", busy_n, 10242);
    chk("frame_busy_fall", bus.busy_o, 0);
    chk("frame_max_stage", max_stg, 9);
    step(1'b0, 1'b1, 1'b0);
    chk("done_single_pulse", bus.done_o, 0);
    chk("done_count", done_seen - mark, 1);

    // Enable toggling, sync_i ignored while disabled
    step(1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b0, 1'b1);
      step(1'b0, 1'b1, 1'b0);
    end
    chk("toggle_index", {bus.stage_o, bus.index_o}, {4'd0, 10'd10});

    // Abort at stage 5, index 300
    mark = done_seen;
    repeat (5 * 1024 + 300 - 10) step(1'b0, 1'b1, 1'b0);
    chk("abort_pos", {bus.stage_o, bus.index_o}, {4'd5, 10'd300});
    step(1'b0, 1'b1, 1'b1);
    chk("abort_restart", {bus.sync_o, bus.stage_o, bus.index_o}, {1'b1, 4'd0, 10'd0});
    chk("abort_no_done", done_seen - mark, 0);

    // Reset mid-RUN with enable low
    repeat (3) step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    chk("midrun_reset", {bus.sel_o, bus.sync_o, bus.index_o, bus.stage_o, bus.busy_o, bus.done_o}, 0);
    step(1'b0, 1'b1, 1'b1);
    chk("post_reset_start", {bus.sync_o, bus.index_o, bus.busy_o}, {1'b1, 10'd0, 1'b1});

    // Restart coincident with the RUN exit condition
    mark = done_seen;
    repeat (10239) step(1'b0, 1'b1, 1'b0);
    chk("exit_pos", {bus.stage_o, bus.index_o}, {4'd9, 10'd1023});
    step(1'b0, 1'b1, 1'b1);
    chk("exit_restart", {bus.sync_o, bus.busy_o, bus.done_o, bus.index_o}, {1'b1, 1'b1, 1'b0, 10'd0});

    // Restart coincident with the last FLUSH cycle
    repeat (10239) step(1'b0, 1'b1, 1'b0);
    repeat (2) step(1'b0, 1'b1, 1'b0);
    chk("flush_state", {bus.sel_o, bus.busy_o, bus.sync_o}, {3'b000, 1'b1, 1'b0});
    step(1'b0, 1'b1, 1'b1);
    chk("flush_restart", {bus.sync_o, bus.done_o, bus.busy_o}, {1'b1, 1'b0, 1'b1});
    chk("boundary_no_done", done_seen - mark, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
